// File: rtl/output_limit_ctrl.sv
// output_limit_ctrl
// Sequences high-speed output reads against a host-registered word count.
// A one-cycle reg_output_limit pulse snapshots the output FIFO fill level
// into output_limit. The block then allows exactly that many word reads.
// With mode_limit low, the block passes reads straight through (bypass).
//
// Optional build macro: OUTPUT_LIMIT_MIN_EN
//   When defined, the block adds the output_limit_min port. In that build,
//   a fill level below the minimum registers as 0, which forces the host
//   to poll again.
module output_limit_ctrl #(
    parameter int                 LIMIT_W   = 16,
    parameter logic [LIMIT_W-1:0] MAX_LIMIT = 16'hFFFF
) (
    input  logic               IFCLK,
    input  logic               RESET_N,
    input  logic               mode_limit,
    input  logic               reg_output_limit,
    input  logic [LIMIT_W-1:0] fifo_words,
    input  logic               fifo_empty,
    input  logic               rd_en,
`ifdef OUTPUT_LIMIT_MIN_EN
    input  logic [LIMIT_W-1:0] output_limit_min,
`endif
    output logic [LIMIT_W-1:0] output_limit,
    output logic               output_limit_not_done,
    output logic               rd_allow,
    output logic               err_rd,
    output logic               err_reg_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BYPASS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LIMIT_W-1:0] output_limit_q, output_limit_d;
    logic [LIMIT_W-1:0] remaining_q, remaining_d;
    logic               not_done_q, not_done_d;
    logic               err_rd_q, err_rd_d;
    logic               err_reg_busy_q, err_reg_busy_d;

    logic [LIMIT_W-1:0] clamped_words;
    logic [LIMIT_W-1:0] snap;
    logic               rd_fire;

    // Snapshot value: the fill level, clamped to the cap (and zeroed below the minimum, if enabled)
    always_comb begin
        clamped_words = (fifo_words > MAX_LIMIT) ? MAX_LIMIT : fifo_words;
`ifdef OUTPUT_LIMIT_MIN_EN
        snap = (fifo_words >= output_limit_min) ? clamped_words : '0;
`else
        snap = clamped_words;
`endif
    end

    // Read permission: follows the FIFO in bypass, is gated by the remaining count when active, and is 0 when idle
    always_comb begin
        rd_allow = 1'b0;
        case (state_q)
            S_BYPASS: rd_allow = !fifo_empty;
            S_ACTIVE: rd_allow = (remaining_q != '0) && !fifo_empty;
            default:  rd_allow = 1'b0;
        endcase
    end

    assign rd_fire = rd_en && rd_allow;

    // Next-state logic: the mode-drop abort takes priority over all per-state handling
    always_comb begin
        state_d        = state_q;
        output_limit_d = output_limit_q;
        remaining_d    = remaining_q;
        not_done_d     = not_done_q;
        err_rd_d       = err_rd_q;
        err_reg_busy_d = err_reg_busy_q;

        // Error flags are sticky; only reset clears them
        if (rd_en && !rd_allow) begin
            err_rd_d = 1'b1;
        end
        if (reg_output_limit && (state_q == S_ACTIVE)) begin
            err_reg_busy_d = 1'b1;
        end

        if (!mode_limit) begin
            state_d     = S_BYPASS;
            remaining_d = '0;
            not_done_d  = 1'b0;
        end else begin
            case (state_q)
                S_BYPASS: begin
                    // A request that arrives on the return cycle is dropped, not deferred
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (reg_output_limit) begin
                        output_limit_d = snap;
                        remaining_d    = snap;
                        if (snap != '0) begin
                            state_d    = S_ACTIVE;
                            not_done_d = 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    // rd_fire implies remaining_q != 0, so the count cannot wrap
                    if (rd_fire) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == LIMIT_W'(1)) begin
                            not_done_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                    not_done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, with synchronous active-low reset
    always_ff @(posedge IFCLK) begin
        if (!RESET_N) begin
            state_q        <= S_IDLE;
            output_limit_q <= '0;
            remaining_q    <= '0;
            not_done_q     <= 1'b0;
            err_rd_q       <= 1'b0;
            err_reg_busy_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            output_limit_q <= output_limit_d;
            remaining_q    <= remaining_d;
            not_done_q     <= not_done_d;
            err_rd_q       <= err_rd_d;
            err_reg_busy_q <= err_reg_busy_d;
        end
    end

    assign output_limit          = output_limit_q;
    assign output_limit_not_done = not_done_q;
    assign err_rd                = err_rd_q;
    assign err_reg_busy          = err_reg_busy_q;

endmodule

// File: tb/tb_output_limit_ctrl.sv
// Testbench for output_limit_ctrl. The DUT is built with a cap of 100 words.
// Each cycle, the bench compares the DUT outputs against a behavioural model
// that tracks the bypass flag, the words remaining and the registered limit.
module tb_output_limit_ctrl;

    localparam int LW   = 16;
    localparam int MAXL = 100;

    logic          IFCLK = 1'b0;
    logic          RESET_N;
    logic          mode_limit;
    logic          reg_output_limit;
    logic [LW-1:0] fifo_words;
    logic          fifo_empty;
    logic          rd_en;
    logic [LW-1:0] output_limit_min;
    logic [LW-1:0] output_limit;
    logic          output_limit_not_done;
    logic          rd_allow;
    logic          err_rd;
    logic          err_reg_busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Behavioural model state
    bit m_bypass;
    int m_rem;
    int m_limit;
    bit m_err_rd;
    bit m_err_busy;

    always #5 IFCLK = ~IFCLK;

    output_limit_ctrl #(
        .LIMIT_W  (LW),
        .MAX_LIMIT(16'd100)
    ) dut (
        .IFCLK                (IFCLK),
        .RESET_N              (RESET_N),
        .mode_limit           (mode_limit),
        .reg_output_limit     (reg_output_limit),
        .fifo_words           (fifo_words),
        .fifo_empty           (fifo_empty),
        .rd_en                (rd_en),
`ifdef OUTPUT_LIMIT_MIN_EN
        .output_limit_min     (output_limit_min),
`endif
        .output_limit         (output_limit),
        .output_limit_not_done(output_limit_not_done),
        .rd_allow             (rd_allow),
        .err_rd               (err_rd),
        .err_reg_busy         (err_reg_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit model_allow();
        if (m_bypass) return !fifo_empty;
        return (m_rem > 0) && !fifo_empty;
    endfunction

    function automatic int model_snap();
        int fw;
        int mn;
        fw = int'(fifo_words);
`ifdef OUTPUT_LIMIT_MIN_EN
        mn = int'(output_limit_min);
`else
        mn = 0;
`endif
        if (fw < mn) return 0;
        return (fw > MAXL) ? MAXL : fw;
    endfunction

    // One clock cycle: check rd_allow against the current inputs, update the model at the edge, then check the registered outputs
    task automatic cycle();
        bit allow;
        #1;
        allow = model_allow();
        check("rd_allow", {31'd0, rd_allow}, {31'd0, allow});
        @(posedge IFCLK);
        if (!RESET_N) begin
            m_bypass   = 0;
            m_rem      = 0;
            m_limit    = 0;
            m_err_rd   = 0;
            m_err_busy = 0;
        end else begin
            if (rd_en && !allow) m_err_rd = 1;
            if (reg_output_limit && !m_bypass && m_rem > 0) m_err_busy = 1;
            if (!mode_limit) begin
                m_bypass = 1;
                m_rem    = 0;
            end else if (m_bypass) begin
                m_bypass = 0;
            end else if (m_rem > 0) begin
                if (rd_en && allow) m_rem = m_rem - 1;
            end else if (reg_output_limit) begin
                m_limit = model_snap();
                m_rem   = m_limit;
            end
        end
        #1;
        check("output_limit", {16'd0, output_limit}, m_limit);
        check("not_done", {31'd0, output_limit_not_done}, {31'd0, (m_rem > 0)});
        check("err_rd", {31'd0, err_rd}, {31'd0, m_err_rd});
        check("err_reg_busy", {31'd0, err_reg_busy}, {31'd0, m_err_busy});
    endtask

    task automatic pulse(input int words);
        fifo_words       = LW'(words);
        reg_output_limit = 1'b1;
        cycle();
        reg_output_limit = 1'b0;
    endtask

    initial begin
        RESET_N          = 1'b0;
        mode_limit       = 1'b1;
        reg_output_limit = 1'b0;
        fifo_words       = '0;
        fifo_empty       = 1'b0;
        rd_en            = 1'b0;
        output_limit_min = '0;
        m_bypass = 0; m_rem = 0; m_limit = 0; m_err_rd = 0; m_err_busy = 0;
        repeat (2) @(posedge IFCLK);

        // Test 1: reset wins over a concurrent request
        RESET_N = 1'b0;
        pulse(50);
        check("t1_limit", {16'd0, output_limit}, 0);
        check("t1_not_done", {31'd0, output_limit_not_done}, 0);
        RESET_N = 1'b1;
        cycle();
        check("t1_rd_allow", {31'd0, rd_allow}, 0);

        // Test 2: nominal five-word transfer
        pulse(5);
        check("t2_limit", {16'd0, output_limit}, 5);
        check("t2_not_done", {31'd0, output_limit_not_done}, 1);
        rd_en = 1'b1;
        repeat (5) cycle();
        rd_en = 1'b0;
        check("t2_done", {31'd0, output_limit_not_done}, 0);
        cycle();
        check("t2_rd_allow", {31'd0, rd_allow}, 0);

        // Test 3: empty FIFO stalls the transfer without losing count
        pulse(3);
        fifo_empty = 1'b1;
        rd_en      = 1'b1;
        repeat (10) cycle();
        check("t3_hold", {31'd0, output_limit_not_done}, 1);
        fifo_empty = 1'b0;
        repeat (3) cycle();
        rd_en = 1'b0;
        check("t3_done", {31'd0, output_limit_not_done}, 0);

        // Reset clears the err_rd flag set by the stalled reads
        RESET_N = 1'b0;
        cycle();
        RESET_N = 1'b1;

        // Test 4: clamp to the cap, and a busy request made mid-read
        pulse(300);
        check("t4_clamp", {16'd0, output_limit}, 100);
        rd_en = 1'b1;
        repeat (2) cycle();
        pulse(40);
        rd_en = 1'b0;
        check("t4_busy", {31'd0, err_reg_busy}, 1);
        check("t4_limit_kept", {16'd0, output_limit}, 100);

        // Test 5: abort into bypass, then an illegal read while idle
        mode_limit = 1'b0;
        cycle();
        mode_limit = 1'b1;
        cycle();
        pulse(8);
        check("t5_limit", {16'd0, output_limit}, 8);
        rd_en = 1'b1;
        repeat (2) cycle();
        rd_en      = 1'b0;
        mode_limit = 1'b0;
        cycle();
        check("t5_abort", {31'd0, output_limit_not_done}, 0);
        fifo_empty = 1'b1;
        cycle();
        fifo_empty = 1'b0;
        cycle();
        mode_limit = 1'b1;
        cycle();
        check("t5_err_rd_clear", {31'd0, err_rd}, 0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t5_err_rd", {31'd0, err_rd}, 1);

`ifdef OUTPUT_LIMIT_MIN_EN
        // Test 6: fill levels below the minimum register as zero
        output_limit_min = 16'd16;
        pulse(10);
        check("t6_below_min", {16'd0, output_limit}, 0);
        check("t6_idle", {31'd0, output_limit_not_done}, 0);
        pulse(16);
        check("t6_at_min", {16'd0, output_limit}, 16);
        mode_limit = 1'b0;
        cycle();
        mode_limit = 1'b1;
        cycle();
`endif

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            RESET_N          = ($urandom_range(0, 99) != 0);
            mode_limit       = ($urandom_range(0, 24) != 0);
            reg_output_limit = ($urandom_range(0, 7) == 0);
            fifo_words       = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 300))
                                                           : LW'($urandom_range(0, 12));
            fifo_empty       = ($urandom_range(0, 4) == 0);
            rd_en            = ($urandom_range(0, 2) != 0);
`ifdef OUTPUT_LIMIT_MIN_EN
            output_limit_min = LW'($urandom_range(0, 8));
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
